// File: rtl/referee_nch_if.sv
// Bus bundle between the source FIFO, the referee and its NUM_CH output channels.
interface referee_nch_if #(
  parameter int LINE_SIZE = 12,
  parameter int NUM_CH    = 4,
  parameter int COUNT_W   = 8
);
  logic                        almost_empty_signal;
  logic [LINE_SIZE-1:0]        data_in;
  logic [NUM_CH-1:0]           almost_full_signal;
  logic                        pop_signal;
  logic [NUM_CH-1:0]           push_signal;
  logic [LINE_SIZE-1:0]        data_out;
  logic [NUM_CH*COUNT_W-1:0]   count_out;
  logic                        busy;

  modport master (
    input  almost_empty_signal, data_in, almost_full_signal,
    output pop_signal, push_signal, data_out, count_out, busy
  );

  modport slave (
    output almost_empty_signal, data_in, almost_full_signal,
    input  pop_signal, push_signal, data_out, count_out, busy
  );
endinterface

// File: rtl/referee_nch.sv
// Moves words one at a time from a source FIFO to one of NUM_CH channels,
// chosen by class field (MODE=0) or round-robin (MODE=1), with saturating per-channel counts.
module referee_nch #(
  parameter int LINE_SIZE = 12,
  parameter int NUM_CH    = 4,
  parameter int MODE      = 0,
  parameter int COUNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  referee_nch_if.master bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       pop_q, pop_d;
  logic [NUM_CH-1:0]          push_q, push_d;
  logic [LINE_SIZE-1:0]       data_out_q, data_out_d;
  logic [LINE_SIZE-1:0]       hold_q, hold_d;
  logic [SEL_W-1:0]           dest_q, dest_d;
  logic [SEL_W-1:0]           rr_q, rr_d;
  logic [NUM_CH*COUNT_W-1:0]  count_q, count_d;
  logic                       busy_q, busy_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == {COUNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + COUNT_W'(1);
    end
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    pop_d      = 1'b0;
    push_d     = '0;
    data_out_d = data_out_q;
    hold_d     = hold_q;
    dest_d     = dest_q;
    rr_d       = rr_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (!bus.almost_empty_signal) begin
          pop_d   = 1'b1;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        hold_d = bus.data_in;
        if (MODE == 0) begin
          dest_d = bus.data_in[LINE_SIZE-1 -: SEL_W];
        end else begin
          dest_d = rr_q;
        end
        state_d = WRITE;
      end
      WRITE, STALL: begin
        // A push frees the hold register, so the next pop may overlap it.
        if (!bus.almost_full_signal[dest_q]) begin
          push_d     = {{(NUM_CH-1){1'b0}}, 1'b1} << dest_q;
          data_out_d = hold_q;
          count_d[int'(dest_q)*COUNT_W +: COUNT_W] =
            sat_inc(count_q[int'(dest_q)*COUNT_W +: COUNT_W]);
          if (MODE != 0) begin
            rr_d = rr_q + SEL_W'(1);
          end else begin
            rr_d = rr_q;
          end
          if (!bus.almost_empty_signal) begin
            pop_d   = 1'b1;
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pop_q      <= 1'b0;
      push_q     <= '0;
      data_out_q <= '0;
      hold_q     <= '0;
      dest_q     <= '0;
      rr_q       <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      hold_q     <= hold_d;
      dest_q     <= dest_d;
      rr_q       <= rr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.pop_signal  = pop_q;
  assign bus.push_signal = push_q;
  assign bus.data_out    = data_out_q;
  assign bus.count_out   = count_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_referee_nch.sv
// Directed bench: three referee_nch configurations fed by small FIFO models.
module tb_referee_nch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  referee_nch_if #(.LINE_SIZE(12), .NUM_CH(4), .COUNT_W(2)) ia ();
  referee_nch_if #(.LINE_SIZE(12), .NUM_CH(4), .COUNT_W(8)) ib ();
  referee_nch_if #(.LINE_SIZE(16), .NUM_CH(8), .COUNT_W(8)) ic ();

  referee_nch #(.LINE_SIZE(12), .NUM_CH(4), .MODE(0), .COUNT_W(2)) u_a (.clk(clk), .reset(reset), .bus(ia.master));
  referee_nch #(.LINE_SIZE(12), .NUM_CH(4), .MODE(1), .COUNT_W(8)) u_b (.clk(clk), .reset(reset), .bus(ib.master));
  referee_nch #(.LINE_SIZE(16), .NUM_CH(8), .MODE(0), .COUNT_W(8)) u_c (.clk(clk), .reset(reset), .bus(ic.master));

  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [15:0] qc[$];
  logic [3:0]  af_a = 4'd0;
  logic [3:0]  af_b = 4'd0;
  logic [7:0]  af_c = 8'd0;
  logic [3:0]  alog_ch[$];
  logic [11:0] alog_d[$];
  logic [3:0]  blog_ch[$];
  logic [11:0] blog_d[$];
  logic [7:0]  clog_ch[$];
  logic [15:0] clog_d[$];
  int          bpop[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          asz;
  logic [3:0]  exp_b[6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ia.almost_empty_signal = (qa.size() == 0);
    ia.data_in             = (qa.size() > 0) ? qa[0] : 12'd0;
    ia.almost_full_signal  = af_a;
    ib.almost_empty_signal = (qb.size() == 0);
    ib.data_in             = (qb.size() > 0) ? qb[0] : 12'd0;
    ib.almost_full_signal  = af_b;
    ic.almost_empty_signal = (qc.size() == 0);
    ic.data_in             = (qc.size() > 0) ? qc[0] : 16'd0;
    ic.almost_full_signal  = af_c;
  endtask

  // One clock: FIFO models pop on a sampled strobe, pushes are logged.
  task automatic step();
    logic pa, pb, pc;
    pa = ia.pop_signal;
    pb = ib.pop_signal;
    pc = ic.pop_signal;
    @(posedge clk);
    #1;
    cyc++;
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    if (pc && qc.size() > 0) void'(qc.pop_front());
    if (ia.push_signal != 4'd0) begin alog_ch.push_back(ia.push_signal); alog_d.push_back(ia.data_out); end
    if (ib.push_signal != 4'd0) begin blog_ch.push_back(ib.push_signal); blog_d.push_back(ib.data_out); end
    if (ic.push_signal != 8'd0) begin clog_ch.push_back(ic.push_signal); clog_d.push_back(ic.data_out); end
    if (ib.pop_signal) bpop.push_back(cyc);
    chk("a_onehot", 64'($onehot0(ia.push_signal)), 64'd1);
    chk("b_onehot", 64'($onehot0(ib.push_signal)), 64'd1);
    drive();
  endtask

  initial begin
    drive();
    #2 reset = 1'b0;
    #20;
    chk("rst_pop",   64'(ia.pop_signal), 64'd0);
    chk("rst_push",  64'(ia.push_signal), 64'd0);
    chk("rst_dout",  64'(ia.data_out), 64'd0);
    chk("rst_count", 64'(ia.count_out), 64'd0);
    chk("rst_busy",  64'(ia.busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    step();
    chk("idle_busy", 64'(ia.busy), 64'd0);
    chk("idle_pop",  64'(ia.pop_signal), 64'd0);

    // Class 3 word; other almost_full bits set must not matter.
    af_a = 4'b0111;
    qa.push_back(12'b110111100100);
    drive();
    step();
    chk("t1_pop",  64'(ia.pop_signal), 64'd1);
    chk("t1_busy", 64'(ia.busy), 64'd1);
    step();
    chk("t1_pop_one", 64'(ia.pop_signal), 64'd0);
    chk("t1_push0",   64'(ia.push_signal), 64'd0);
    step();
    chk("t1_push",  64'(ia.push_signal), 64'b1000);
    chk("t1_dout",  64'(ia.data_out), 64'b110111100100);
    chk("t1_cnt3",  64'(ia.count_out[7:6]), 64'd1);
    step();
    chk("t1_push_end", 64'(ia.push_signal), 64'd0);
    chk("t1_dout_hold", 64'(ia.data_out), 64'b110111100100);
    chk("t1_idle", 64'(ia.busy), 64'd0);

    // Stall on channel 2 for five cycles while another word waits.
    af_a = 4'b0100;
    qa.push_back(12'b100101101100);
    qa.push_back(12'h001);
    drive();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_stall_push", 64'(ia.push_signal), 64'd0);
      chk("t2_stall_pop",  64'(ia.pop_signal), 64'd0);
      chk("t2_stall_busy", 64'(ia.busy), 64'd1);
    end
    af_a = 4'b0000;
    drive();
    step();
    chk("t2_push", 64'(ia.push_signal), 64'b0100);
    chk("t2_dout", 64'(ia.data_out), 64'b100101101100);
    chk("t2_pop_overlap", 64'(ia.pop_signal), 64'd1);
    step();
    chk("t2_gap", 64'(ia.push_signal), 64'd0);
    step();
    chk("t2_push2", 64'(ia.push_signal), 64'b0001);
    chk("t2_dout2", 64'(ia.data_out), 64'h001);
    chk("t2_cnt2", 64'(ia.count_out[5:4]), 64'd1);
    chk("t2_cnt0", 64'(ia.count_out[1:0]), 64'd1);
    step();

    // Five class-1 words into a 2-bit counter.
    asz = alog_ch.size();
    for (int i = 0; i < 5; i++) qa.push_back(12'h400 + 12'(i));
    drive();
    for (int i = 0; i < 14; i++) step();
    chk("t3_npush", 64'(alog_ch.size() - asz), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_ch",   64'(alog_ch[asz+i]), 64'b0010);
      chk("t3_data", 64'(alog_d[asz+i]), 64'(12'h400 + 12'(i)));
    end
    chk("t3_sat", 64'(ia.count_out[3:2]), 64'd3);

    // Round-robin over six words.
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 6; i++) qb.push_back(12'h101 + 12'(i));
    drive();
    for (int i = 0; i < 16; i++) step();
    chk("t4_npush", 64'(blog_ch.size()), 64'd6);
    chk("t4_npop",  64'(bpop.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t4_ch",   64'(blog_ch[i]), 64'(exp_b[i]));
      chk("t4_data", 64'(blog_d[i]), 64'(12'h101 + 12'(i)));
    end
    for (int i = 1; i < 6; i++) chk("t4_pop_gap", 64'(bpop[i] - bpop[i-1]), 64'd2);
    chk("t4_cnt0", 64'(ib.count_out[7:0]), 64'd2);
    chk("t4_cnt1", 64'(ib.count_out[15:8]), 64'd2);
    chk("t4_cnt2", 64'(ib.count_out[23:16]), 64'd1);
    chk("t4_cnt3", 64'(ib.count_out[31:24]), 64'd1);

    // Eight channels, 16-bit word, class field 3'b101.
    qc.push_back(16'hA000);
    drive();
    for (int i = 0; i < 5; i++) step();
    chk("t5_npush", 64'(clog_ch.size()), 64'd1);
    chk("t5_ch",    64'(clog_ch[0]), 64'b00100000);
    chk("t5_data",  64'(clog_d[0]), 64'hA000);
    chk("t5_cnt5",  64'(ic.count_out[47:40]), 64'd1);

    // Reset while a word sits in STALL.
    af_a = 4'b0010;
    qa.push_back(12'h4AA);
    drive();
    step();
    step();
    step();
    chk("t6_stall_busy", 64'(ia.busy), 64'd1);
    asz = alog_ch.size();
    #2 reset = 1'b0;
    #1;
    chk("t6_pop",   64'(ia.pop_signal), 64'd0);
    chk("t6_push",  64'(ia.push_signal), 64'd0);
    chk("t6_dout",  64'(ia.data_out), 64'd0);
    chk("t6_count", 64'(ia.count_out), 64'd0);
    chk("t6_busy",  64'(ia.busy), 64'd0);
    af_a = 4'b0000;
    drive();
    step();
    step();
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t6_no_push", 64'(alog_ch.size() - asz), 64'd0);
    chk("t6_idle", 64'(ia.busy), 64'd0);
    qa.push_back(12'h001);
    drive();
    for (int i = 0; i < 4; i++) step();
    chk("t6_recover_n",  64'(alog_ch.size() - asz), 64'd1);
    chk("t6_recover_ch", 64'(alog_ch[asz]), 64'b0001);
    chk("t6_recover_d",  64'(alog_d[asz]), 64'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/referee_nch.md
REFEREE_NCH -- requirements
Module: referee_nch

Interface
REQ-001 Parameter LINE_SIZE, default 12, width of one transaction word.
REQ-002 Parameter NUM_CH, default 4, number of output channels; legal values are powers of two from 2 to 16; SEL_W = log2(NUM_CH).
REQ-003 Parameter MODE, default 0; 0 routes by class field, 1 distributes round-robin.
REQ-004 Parameter COUNT_W, default 8, width of each per-channel word counter.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
REQ-007 Port almost_empty_signal, input, 1, high means the source FIFO must not be popped.
REQ-008 Port data_in, input, LINE_SIZE, source FIFO read data, valid the cycle after pop_signal.
REQ-009 Port almost_full_signal, input, NUM_CH, bit i high means channel i must not be pushed.
REQ-010 Port pop_signal, output, 1, registered one-cycle source read strobe.
REQ-011 Port push_signal, output, NUM_CH, registered one-hot channel write strobe.
REQ-012 Port data_out, output, LINE_SIZE, registered word, valid while any push_signal bit is high.
REQ-013 Port count_out, output, NUM_CH*COUNT_W, packed counters; channel i occupies bits [i*COUNT_W +: COUNT_W].
REQ-014 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states are IDLE, READ, WRITE and STALL; every output is registered.
REQ-016 IDLE: if almost_empty_signal=0, assert pop_signal for one cycle and go to READ; otherwise stay in IDLE.
REQ-017 READ: capture data_in into the hold register; compute dest; go to WRITE.
REQ-018 MODE=0: dest = hold[LINE_SIZE-1 -: SEL_W].
REQ-019 MODE=1: dest = round-robin pointer; the pointer advances by 1 modulo NUM_CH only after a completed push.
REQ-020 WRITE/STALL when almost_full_signal[dest]=0: on the next cycle assert push_signal[dest] for exactly one cycle with data_out = hold.
REQ-021 On the push of REQ-020, increment counter[dest].
REQ-022 On the push of REQ-020, go to READ with pop_signal asserted if almost_empty_signal=0; otherwise go to IDLE.
REQ-023 WRITE/STALL when almost_full_signal[dest]=1: go to or remain in STALL with push_signal=0 and the hold register unchanged.
REQ-024 Throughput is at most one word per two cycles; pop of the next word overlaps the push of the current word.
REQ-025 Words are never dropped, duplicated or reordered; at most one word is held at a time.
REQ-026 push_signal is always zero or one-hot; pop_signal is never asserted while a word sits in STALL.
REQ-027 Counters saturate at 2^COUNT_W-1 and do not wrap.
REQ-028 data_out holds its last pushed value when push_signal=0.
REQ-029 almost_full_signal bits other than dest never affect progress.
REQ-030 A change of almost_empty_signal during READ or WRITE does not affect the word already popped.

Reset
REQ-031 While reset=0: state=IDLE, pop_signal=0, push_signal=0, data_out=0, hold register=0, all counters=0, RR pointer=0, busy=0.
REQ-032 Reset asserted mid-transfer discards the held word; after release the first pop occurs no earlier than the first rising edge with reset=1.

Verification
REQ-033 MODE=0, reset release, almost_empty 1->0, data_in=12'b110111100100 -> pop one cycle, then push_signal=4'b1000 with data_out=12'b110111100100, count ch3=1.
REQ-034 MODE=0, data_in=12'b100101101100 with almost_full=4'b0100 for 5 cycles -> STALL, push_signal=0, pop_signal=0; on release -> push_signal=4'b0100 once, no word lost.
REQ-035 MODE=1, almost_empty=0, 6 words, almost_full=0 -> pushes on channels 0,1,2,3,0,1, each counter as expected, pops spaced 2 cycles apart.
REQ-036 COUNT_W=2, 5 words to channel 1 -> count ch1 saturates at 3.
REQ-037 Reset driven low during STALL -> all outputs 0 asynchronously; after release, no push of the discarded word.
REQ-038 NUM_CH=8, LINE_SIZE=16, word 16'hA000 -> push_signal=8'b00100000 (class field 3'b101 selects channel 5).
